// File: rtl/min_disp_drv.sv
// Minute display driver: converts a 6-bit binary minute to two BCD digits by
// repeated subtraction and scans them onto a 2-digit multiplexed 7-segment display.
module min_disp_drv #(
    parameter int SCAN_DIV   = 4,
    parameter bit BLANK_LEAD = 1'b0
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic [5:0] min_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       busy,
    output logic       err
);
    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_ZERO = 7'b0111111;

    logic [0:0]       state;
    logic [5:0]       last_val;
    logic [5:0]       work;
    logic [2:0]       tens_acc;
    logic [2:0]       tens_r;
    logic [3:0]       ones_r;
    logic [CNT_W-1:0] scan_cnt;
    logic             digit_sel;
    logic [3:0]       cur_digit;
    logic [6:0]       seg_nxt;

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0:    seg_glyph = 7'h3F;
            4'd1:    seg_glyph = 7'h06;
            4'd2:    seg_glyph = 7'h5B;
            4'd3:    seg_glyph = 7'h4F;
            4'd4:    seg_glyph = 7'h66;
            4'd5:    seg_glyph = 7'h6D;
            4'd6:    seg_glyph = 7'h7D;
            4'd7:    seg_glyph = 7'h07;
            4'd8:    seg_glyph = 7'h7F;
            4'd9:    seg_glyph = 7'h6F;
            default: seg_glyph = 7'h00;
        endcase
    endfunction

    // Conversion FSM: one subtraction of 10 per cycle, results committed on exit
    always_ff @(posedge inclk) begin
        if (rst) begin
            state    <= IDLE;
            last_val <= '0;
            work     <= '0;
            tens_acc <= '0;
            tens_r   <= '0;
            ones_r   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (min_in != last_val) begin
                        last_val <= min_in;
                        if (min_in > 6'd59) begin
                            err <= 1'b1;
                        end else begin
                            work     <= min_in;
                            tens_acc <= '0;
                            busy     <= 1'b1;
                            state    <= CONV;
                        end
                    end
                end
                default: begin
                    if (work >= 6'd10) begin
                        work     <= work - 6'd10;
                        tens_acc <= tens_acc + 3'd1;
                    end else begin
                        tens_r <= tens_acc;
                        ones_r <= work[3:0];
                        err    <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cur_digit = digit_sel ? {1'b0, tens_r} : ones_r;
        if (err)
            seg_nxt = SEG_DASH;
        else if (BLANK_LEAD && digit_sel && (tens_r == 3'd0))
            seg_nxt = 7'b0000000;
        else
            seg_nxt = seg_glyph(cur_digit);
    end

    // Scan and output register: outputs reflect the pre-edge selection, one cycle behind
    always_ff @(posedge inclk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_sel <= 1'b0;
            an        <= 2'b01;
            seg       <= SEG_ZERO;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= digit_sel ? 2'b10 : 2'b01;
            seg <= seg_nxt;
        end
    end

endmodule
